// File: rtl/video_timing_pkg.sv
`default_nettype none
// ============================================================================
// video_timing_pkg : shared widths, sync bundle and window helper for the
// raster timing generator.                                   Rev 1.0
// ============================================================================
package video_timing_pkg;

  localparam int HCNT_W = 10;
  localparam int VCNT_W = 9;

  typedef struct packed {
    logic hs;
    logic vs;
    logic hb;
    logic vb;
  } sync_t;

  // True while start <= count < start+len.
  function automatic logic in_window(input int count, input int start, input int len);
    return (count >= start) && (count < start + len);
  endfunction

endpackage
`default_nettype wire

// File: rtl/video_ce_div.sv
`default_nettype none
// ============================================================================
// video_ce_div : divides clk_sys into a registered one-cycle clock-enable,
// high once every CE_DIV cycles.                             Rev 1.0
// ============================================================================
module video_ce_div #(
  parameter int CE_DIV = 4
) (
  input  logic clk_sys,
  input  logic reset_n,
  output logic ce
);

  localparam int              c_W    = $clog2(CE_DIV);
  localparam logic [c_W-1:0]  c_LAST = c_W'(CE_DIV - 1);

  logic [c_W-1:0] cnt_q, cnt_d;
  logic           ce_q, ce_d;

  always_comb begin
    ce_d  = (cnt_q == c_LAST);
    cnt_d = ce_d ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ce_q  <= ce_d;
    end
  end

  assign ce = ce_q;

endmodule
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// video_timing_gen : pixel enable, raster counters, syncs/blanks and NTSC/PAL
// frame length. VIDEO_TIMING_TESTPAT_EN adds colour-bar R/G/B.   Rev 1.0
// ============================================================================
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int CE_DIV       = 4,
  parameter int H_TOTAL      = 456,
  parameter int H_ACTIVE     = 320,
  parameter int H_SYNC_START = 360,
  parameter int H_SYNC_LEN   = 34,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 244,
  parameter int V_SYNC_LEN   = 3,
  parameter int V_TOTAL_NTSC = 262,
  parameter int V_TOTAL_PAL  = 312
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              pal,
  output logic              ce_pix,
  output logic [HCNT_W-1:0] hcount,
  output logic [VCNT_W-1:0] vcount,
  output logic              HSync,
  output logic              VSync,
  output logic              HBlank,
  output logic              VBlank,
  output logic              line_start,
  output logic              frame_start,
  output logic              pal_active
`ifdef VIDEO_TIMING_TESTPAT_EN
  ,
  output logic [7:0]        R,
  output logic [7:0]        G,
  output logic [7:0]        B
`endif
);

  if (H_SYNC_START + H_SYNC_LEN > H_TOTAL) begin : g_chk_hsync
    $error("video_timing_gen: HSync window exceeds H_TOTAL");
  end
  if (V_SYNC_START + V_SYNC_LEN > V_TOTAL_NTSC) begin : g_chk_vsync
    $error("video_timing_gen: VSync window exceeds V_TOTAL_NTSC");
  end
  if (H_ACTIVE > H_SYNC_START) begin : g_chk_hactive
    $error("video_timing_gen: H_ACTIVE must not exceed H_SYNC_START");
  end
  if (CE_DIV < 4) begin : g_chk_cediv
    $error("video_timing_gen: CE_DIV must be at least 4");
  end
  if (H_TOTAL > 768) begin : g_chk_htotal
    $error("video_timing_gen: H_TOTAL exceeds downstream line length");
  end

  localparam logic [HCNT_W-1:0] c_H_LAST      = HCNT_W'(H_TOTAL - 1);
  localparam logic [VCNT_W-1:0] c_V_LAST_NTSC = VCNT_W'(V_TOTAL_NTSC - 1);
  localparam logic [VCNT_W-1:0] c_V_LAST_PAL  = VCNT_W'(V_TOTAL_PAL - 1);

  logic              ce;
  logic [HCNT_W-1:0] h_q, h_d;
  logic [VCNT_W-1:0] v_q, v_d;
  logic              pal_q, pal_d;
  sync_t             sync_q, sync_d;
  logic              lz_q, lz_d;
  logic              fz_q, fz_d;

  video_ce_div #(
    .CE_DIV (CE_DIV)
  ) u_ce_div (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce)
  );

  // Frame length is decided by the standard latched at the previous wrap.
  always_comb begin
    h_d   = h_q;
    v_d   = v_q;
    pal_d = pal_q;
    if (ce) begin
      if (h_q == c_H_LAST) begin
        h_d = '0;
        if (v_q == (pal_q ? c_V_LAST_PAL : c_V_LAST_NTSC)) begin
          v_d   = '0;
          pal_d = pal;
        end else begin
          v_d = v_q + 1'b1;
        end
      end else begin
        h_d = h_q + 1'b1;
      end
    end
    sync_d.hs = in_window(int'(h_d), H_SYNC_START, H_SYNC_LEN);
    sync_d.vs = in_window(int'(v_d), V_SYNC_START, V_SYNC_LEN);
    sync_d.hb = (int'(h_d) >= H_ACTIVE);
    sync_d.vb = (int'(v_d) >= V_ACTIVE);
    lz_d      = (h_d == '0);
    fz_d      = lz_d && (v_d == '0);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      h_q    <= '0;
      v_q    <= '0;
      pal_q  <= 1'b0;
      sync_q <= '0;
      lz_q   <= 1'b0;
      fz_q   <= 1'b0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      pal_q  <= pal_d;
      sync_q <= sync_d;
      lz_q   <= lz_d;
      fz_q   <= fz_d;
    end
  end

  assign ce_pix      = ce;
  assign hcount      = h_q;
  assign vcount      = v_q;
  assign HSync       = sync_q.hs;
  assign VSync       = sync_q.vs;
  assign HBlank      = sync_q.hb;
  assign VBlank      = sync_q.vb;
  assign line_start  = ce & lz_q;
  assign frame_start = ce & fz_q;
  assign pal_active  = pal_q;

`ifdef VIDEO_TIMING_TESTPAT_EN
  logic [2:0]  bar_d;
  logic [23:0] rgb_q, rgb_d;

  always_comb begin
    bar_d = 3'((int'(h_d) * 8) / H_ACTIVE);
    rgb_d = '0;
    if (!sync_d.hb && !sync_d.vb) begin
      rgb_d = {{8{bar_d[1]}}, {8{bar_d[2]}}, {8{bar_d[0]}}};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign R = rgb_q[23:16];
  assign G = rgb_q[15:8];
  assign B = rgb_q[7:0];
`endif

endmodule
`default_nettype wire

// File: tb/tb_video_timing_gen.sv
`default_nettype none
// ============================================================================
// tb_video_timing_gen : randomized pal stimulus against a pixel-index raster
// model, with a scoreboard popped on every ce_pix.           Rev 1.0
// ============================================================================
module tb_video_timing_gen;

  // Shrunk raster so several whole frames fit in a short run.
  localparam int T_CE  = 4;
  localparam int T_HT  = 40;
  localparam int T_HA  = 24;
  localparam int T_HSS = 28;
  localparam int T_HSL = 5;
  localparam int T_VA  = 10;
  localparam int T_VSS = 12;
  localparam int T_VSL = 2;
  localparam int T_VN  = 16;
  localparam int T_VP  = 20;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       pal     = 1'b0;
  logic       ce_pix;
  logic [9:0] hcount;
  logic [8:0] vcount;
  logic       HSync, VSync, HBlank, VBlank, line_start, frame_start, pal_active;
`ifdef VIDEO_TIMING_TESTPAT_EN
  logic [7:0] R, G, B;
`endif

  always #5 clk_sys = ~clk_sys;

  video_timing_gen #(
    .CE_DIV       (T_CE),
    .H_TOTAL      (T_HT),
    .H_ACTIVE     (T_HA),
    .H_SYNC_START (T_HSS),
    .H_SYNC_LEN   (T_HSL),
    .V_ACTIVE     (T_VA),
    .V_SYNC_START (T_VSS),
    .V_SYNC_LEN   (T_VSL),
    .V_TOTAL_NTSC (T_VN),
    .V_TOTAL_PAL  (T_VP)
  ) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .pal         (pal),
    .ce_pix      (ce_pix),
    .hcount      (hcount),
    .vcount      (vcount),
    .HSync       (HSync),
    .VSync       (VSync),
    .HBlank      (HBlank),
    .VBlank      (VBlank),
    .line_start  (line_start),
    .frame_start (frame_start),
    .pal_active  (pal_active)
`ifdef VIDEO_TIMING_TESTPAT_EN
    ,
    .R           (R),
    .G           (G),
    .B           (B)
`endif
  );

  typedef struct {
    int h;
    int v;
    bit hs, vs, hb, vb, ls, fs, pa;
    int r, g, b;
  } exp_t;

  exp_t q[$];
  exp_t m_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected raster state for pixel number pix inside the current frame.
  function automatic exp_t predict(input int pix, input bit pa);
    exp_t e;
    int   bar;
    e.h  = pix % T_HT;
    e.v  = pix / T_HT;
    e.hs = (e.h >= T_HSS) && (e.h < T_HSS + T_HSL);
    e.vs = (e.v >= T_VSS) && (e.v < T_VSS + T_VSL);
    e.hb = (e.h >= T_HA);
    e.vb = (e.v >= T_VA);
    e.ls = (e.h == 0);
    e.fs = (pix == 0);
    e.pa = pa;
    e.r  = 0;
    e.g  = 0;
    e.b  = 0;
    if (!e.hb && !e.vb) begin
      bar = e.h * 8 / T_HA;
      e.r = bar[1] ? 255 : 0;
      e.g = bar[2] ? 255 : 0;
      e.b = bar[0] ? 255 : 0;
    end
    return e;
  endfunction

  task automatic reset_checks(input string pfx);
    check({pfx, "_ce_pix"}, ce_pix, 0);
    check({pfx, "_hcount"}, hcount, 0);
    check({pfx, "_vcount"}, vcount, 0);
    check({pfx, "_HSync"}, HSync, 0);
    check({pfx, "_VSync"}, VSync, 0);
    check({pfx, "_HBlank"}, HBlank, 0);
    check({pfx, "_VBlank"}, VBlank, 0);
    check({pfx, "_line_start"}, line_start, 0);
    check({pfx, "_frame_start"}, frame_start, 0);
    check({pfx, "_pal_active"}, pal_active, 0);
`ifdef VIDEO_TIMING_TESTPAT_EN
    check({pfx, "_R"}, R, 0);
    check({pfx, "_G"}, G, 0);
    check({pfx, "_B"}, B, 0);
`endif
  endtask

  // Monitor: every ce_pix consumes one expected pixel.
  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (ce_pix) begin
        check("ce_expected", q.size(), 1);
        if (q.size() != 0) begin
          m_e = q.pop_front();
          check("hcount", hcount, m_e.h);
          check("vcount", vcount, m_e.v);
          check("HSync", HSync, m_e.hs);
          check("VSync", VSync, m_e.vs);
          check("HBlank", HBlank, m_e.hb);
          check("VBlank", VBlank, m_e.vb);
          check("line_start", line_start, m_e.ls);
          check("frame_start", frame_start, m_e.fs);
          check("pal_active", pal_active, m_e.pa);
`ifdef VIDEO_TIMING_TESTPAT_EN
          check("R", R, m_e.r);
          check("G", G, m_e.g);
          check("B", B, m_e.b);
`endif
        end
      end else begin
        check("pulse_idle", int'(line_start | frame_start), 0);
        if (q.size() != 0) begin
          void'(q.pop_front());
          check("ce_pix_missing", ce_pix, 1);
        end
      end
    end
  end

  initial begin
    int   pix;
    bit   pa;
    int   n;
    int   cyc;
    bit   did_rst;
    exp_t e;
    pix     = 0;
    pa      = 1'b0;
    n       = 0;
    cyc     = 0;
    did_rst = 1'b0;

    reset_n = 1'b0;
    pal     = 1'($urandom_range(0, 1));
    repeat (3) @(negedge clk_sys);
    reset_checks("rst");
    reset_n = 1'b1;

    while (cyc < 60000) begin
      @(posedge clk_sys);
      #1;
      n++;
      cyc++;
      if (n % T_CE == 0) begin
        e = predict(pix, pa);
        q.push_back(e);
        if ($urandom_range(0, 199) == 0) pal = ~pal;
        pix++;
        if (pix == (pa ? T_VP : T_VN) * T_HT) begin
          // Half the wraps also flip pal in the wrap cycle itself.
          if ($urandom_range(0, 1) == 1) pal = ~pal;
          pix = 0;
          pa  = pal;
        end
        if (!did_rst && cyc > 25000 && e.h == 20 && e.v == 7) begin
          did_rst = 1'b1;
          @(negedge clk_sys);
          #1;
          check("pre_rst_hcount", hcount, 20);
          check("pre_rst_vcount", vcount, 7);
          reset_n = 1'b0;
          #1;
          reset_checks("async_rst");
          check("q_at_rst", q.size(), 0);
          q.delete();
          repeat (2) @(posedge clk_sys);
          @(negedge clk_sys);
          reset_checks("rst_hold");
          reset_n = 1'b1;
          n   = 0;
          pix = 0;
          pa  = 1'b0;
        end
      end
    end

    repeat (2) @(negedge clk_sys);
    #1;
    check("q_drained", q.size(), 0);
    check("mid_reset_done", int'(did_rst), 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
